// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined immediate generator: format codes and handshake states.
package imm_pkg;

  localparam int IMM_SRC_W = 3;

  localparam logic [IMM_SRC_W-1:0] IMM_I  = 3'b000;
  localparam logic [IMM_SRC_W-1:0] IMM_S  = 3'b001;
  localparam logic [IMM_SRC_W-1:0] IMM_B  = 3'b010;
  localparam logic [IMM_SRC_W-1:0] IMM_J  = 3'b011;
  localparam logic [IMM_SRC_W-1:0] IMM_U  = 3'b100;
  localparam logic [IMM_SRC_W-1:0] IMM_SH = 3'b101;

  // Encoding is {main_valid, skid_valid}; 2'b01 can never be reached.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } pipe_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32/RV64 immediate extraction and extension to XLEN.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]          instr,
  input  logic [IMM_SRC_W-1:0] imm_src,
  output logic [XLEN-1:0]      imm,
  output logic                 illegal
);

  // Build at 64 bits and truncate so XLEN=32 needs no zero-width replication.
  logic [63:0] imm_wide;
  logic        unused_bits;

  always_comb begin
    imm_wide = '0;
    illegal  = 1'b0;
    case (imm_src)
      IMM_I:  imm_wide = {{52{instr[31]}}, instr[31:20]};
      IMM_S:  imm_wide = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:  imm_wide = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:  imm_wide = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:  imm_wide = {{32{instr[31]}}, instr[31:12], 12'b0};
      IMM_SH: imm_wide = (XLEN == 64) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
      default: begin
        imm_wide = '0;
        illegal  = 1'b1;
      end
    endcase
  end

  assign imm         = imm_wide[XLEN-1:0];
  assign unused_bits = ^{imm_wide, instr[6:0]};

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with valid/ready handshake and a one-entry skid buffer.
// Optional `IMM_CHECK_EN adds the out_err port that flags illegal format codes per entry.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [IMM_SRC_W-1:0] in_imm_src,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_imm,
  output logic [TAG_W-1:0]     out_tag
`ifdef IMM_CHECK_EN
  ,output logic                out_err
`endif
);

  // state    | meaning
  // ST_EMPTY | nothing held, output invalid
  // ST_ONE   | main register holds the output entry
  // ST_FULL  | main plus skid hold entries, input stalled

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  pipe_state_e state, state_next;
  logic        in_xfer, out_xfer;
  logic        load_main_in, load_main_skid, load_skid;

  logic [XLEN-1:0]  dec_imm;
  logic             dec_illegal;
  logic [XLEN-1:0]  main_imm, skid_imm;
  logic [TAG_W-1:0] main_tag, skid_tag;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm_src (in_imm_src),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  assign out_valid = state[1];
  assign in_ready  = !state[0];
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_next   = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end else if (in_xfer) begin
          state_next = ST_FULL;
          load_skid  = 1'b1;
        end else if (out_xfer) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          state_next     = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
    // Flush overrides every transfer, including one offered this cycle.
    if (flush) begin
      state_next     = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_imm <= '0;
      main_tag <= '0;
      skid_imm <= '0;
      skid_tag <= '0;
    end else begin
      if (load_main_in) begin
        main_imm <= dec_imm;
        main_tag <= in_tag;
      end else if (load_main_skid) begin
        main_imm <= skid_imm;
        main_tag <= skid_tag;
      end
      if (load_skid) begin
        skid_imm <= dec_imm;
        skid_tag <= in_tag;
      end
    end
  end

  assign out_imm = main_imm;
  assign out_tag = main_tag;

`ifdef IMM_CHECK_EN
  logic main_err, skid_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_err <= 1'b0;
      skid_err <= 1'b0;
    end else begin
      if (load_main_in)        main_err <= dec_illegal;
      else if (load_main_skid) main_err <= skid_err;
      if (load_skid)           skid_err <= dec_illegal;
    end
  end

  assign out_err = main_err;
`else
  logic unused_illegal;
  assign unused_illegal = dec_illegal;
`endif

endmodule
